// File: rtl/uart_apb_arbiter_if.sv
// ============================================================================
// Module      : uart_apb_arbiter_if
// Description : Bundle of the requester-side handshake and the APB master bus
//               of uart_apb_arbiter. The "master" modport is the arbiter's
//               view. The "slave" modport is the environment's view, meaning
//               the two requesters plus the uart_top APB slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface uart_apb_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    // requester side
    logic [1:0]          req_i;
    logic [1:0]          write_i;
    logic [2*ADDR_W-1:0] addr_i;
    logic [2*DATA_W-1:0] wdata_i;
    logic [1:0]          gnt_o;
    logic [1:0]          done_o;
    logic [DATA_W-1:0]   rdata_o;
    logic                err_o;
    // APB side
    logic [ADDR_W-1:0]   PADDR_o;
    logic                PWRITE_o;
    logic [DATA_W-1:0]   PWDATA_o;
    logic                PSEL_o;
    logic                PENABLE_o;
    logic [DATA_W-1:0]   PRDATA_i;
    logic                PREADY_i;
    logic                PSLVERR_i;

    modport master (
        input  req_i, write_i, addr_i, wdata_i,
        output gnt_o, done_o, rdata_o, err_o,
        output PADDR_o, PWRITE_o, PWDATA_o, PSEL_o, PENABLE_o,
        input  PRDATA_i, PREADY_i, PSLVERR_i
    );

    modport slave (
        output req_i, write_i, addr_i, wdata_i,
        input  gnt_o, done_o, rdata_o, err_o,
        input  PADDR_o, PWRITE_o, PWDATA_o, PSEL_o, PENABLE_o,
        output PRDATA_i, PREADY_i, PSLVERR_i
    );
endinterface

`default_nettype wire

// File: rtl/uart_apb_arbiter.sv
// ============================================================================
// Module      : uart_apb_arbiter
// Description : Round-robin arbiter for two requesters in front of the
//               uart_top APB slave. Runs one SETUP/ACCESS transfer at a time.
//               Supports wait states and aborts with an error when PREADY
//               never arrives.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_apb_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               PCLK_i,
    input  logic               PRESETn_i,
    uart_apb_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_SETUP  = 2'd1;
    localparam logic [1:0] C_ACCESS = 2'd2;
    localparam logic [1:0] C_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [1:0]        r_state;
    logic              r_last;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_gnt;
    logic [1:0]        r_done;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_psel;
    logic              r_penable;

    logic              w_win;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_write;

    // Round-robin pick: on a tie the requester granted last time loses
    always_comb begin
        w_win = 1'b0;
        case (bus.req_i)
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last;
            default: w_win = 1'b0;
        endcase
    end

    // Select the winner's payload slice
    always_comb begin
        w_addr  = w_win ? bus.addr_i[ADDR_W +: ADDR_W]  : bus.addr_i[0 +: ADDR_W];
        w_wdata = w_win ? bus.wdata_i[DATA_W +: DATA_W] : bus.wdata_i[0 +: DATA_W];
        w_write = w_win ? bus.write_i[1]                : bus.write_i[0];
    end

    // Transfer sequencer. Every output comes straight from a flop.
    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            r_state   <= C_IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_gnt     <= 2'b00;
            r_done    <= 2'b00;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (|bus.req_i) begin
                        r_paddr   <= w_addr;
                        r_pwrite  <= w_write;
                        r_pwdata  <= w_wdata;
                        r_gnt     <= w_win ? 2'b10 : 2'b01;
                        r_last    <= w_win;
                        r_cnt     <= '0;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= C_SETUP;
                    end
                end
                C_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= C_ACCESS;
                end
                C_ACCESS: begin
                    if (bus.PREADY_i) begin
                        r_rdata   <= r_pwrite ? '0 : bus.PRDATA_i;
                        r_err     <= bus.PSLVERR_i;
                        r_done    <= r_gnt;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= C_DONE;
                    end else if (r_cnt == C_CNT_LAST) begin
                        // slave never answered: report it as an error
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_done    <= r_gnt;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= C_DONE;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                C_DONE: begin
                    // no arbitration here. That is why a requester may drop
                    // req on the edge that samples done.
                    r_gnt   <= 2'b00;
                    r_done  <= 2'b00;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                    r_state <= C_IDLE;
                end
                default: r_state <= C_IDLE;
            endcase
        end
    end

    assign bus.gnt_o     = r_gnt;
    assign bus.done_o    = r_done;
    assign bus.rdata_o   = r_rdata;
    assign bus.err_o     = r_err;
    assign bus.PADDR_o   = r_paddr;
    assign bus.PWRITE_o  = r_pwrite;
    assign bus.PWDATA_o  = r_pwdata;
    assign bus.PSEL_o    = r_psel;
    assign bus.PENABLE_o = r_penable;

endmodule

`default_nettype wire

// File: tb/tb_uart_apb_arbiter.sv
// ============================================================================
// Module      : tb_uart_apb_arbiter
// Description : Directed, scoreboard-based bench for uart_apb_arbiter. It has
//               an APB slave model with programmable wait states, a stall
//               mode and an error address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_apb_arbiter;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [1:0] done;
        logic [7:0] rd;
        logic       err;
    } exp_t;

    typedef struct {
        logic [9:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    uart_apb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    uart_apb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK_i    (clk),
        .PRESETn_i (rstn),
        .bus       (bus.master)
    );

    // requester drive
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       wr0 = 1'b0, wr1 = 1'b0;
    logic [9:0] a0 = '0, a1 = '0;
    logic [7:0] d0 = '0, d1 = '0;

    assign bus.req_i   = {req1, req0};
    assign bus.write_i = {wr1, wr0};
    assign bus.addr_i  = {a1, a0};
    assign bus.wdata_i = {d1, d0};

    // slave model
    int         ws       = 0;
    logic       stall    = 1'b0;
    logic [9:0] err_addr = 10'h3FF;
    int         acc_cnt;
    wr_t        wlog[$];

    function automatic logic [7:0] slave_data(input logic [9:0] a);
        return a[7:0] ^ 8'h1E;
    endfunction

    assign bus.PREADY_i  = stall ? 1'b0 : ((ws == 0) ? 1'b1 : (acc_cnt >= ws));
    assign bus.PRDATA_i  = slave_data(bus.PADDR_o);
    assign bus.PSLVERR_i = (bus.PADDR_o == err_addr);

    // count elapsed ACCESS cycles of the current transfer
    always @(posedge clk or negedge rstn) begin
        if (!rstn)
            acc_cnt <= 0;
        else if (bus.PSEL_o && bus.PENABLE_o)
            acc_cnt <= acc_cnt + 1;
        else
            acc_cnt <= 0;
    end

    // record completed, error-free writes
    always @(posedge clk) begin
        if (rstn && bus.PSEL_o && bus.PENABLE_o && bus.PREADY_i && bus.PWRITE_o && !bus.PSLVERR_i)
            wlog.push_back('{a: bus.PADDR_o, d: bus.PWDATA_o});
    end

    // bookkeeping
    int   vectors = 0;
    int   fails   = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   order[$];
    int   setup_cyc = 0, acc_cyc = 0, gnt_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},     32'(bus.gnt_o),     32'd0);
        check({tag, "_done"},    32'(bus.done_o),    32'd0);
        check({tag, "_rdata"},   32'(bus.rdata_o),   32'd0);
        check({tag, "_err"},     32'(bus.err_o),     32'd0);
        check({tag, "_paddr"},   32'(bus.PADDR_o),   32'd0);
        check({tag, "_pwrite"},  32'(bus.PWRITE_o),  32'd0);
        check({tag, "_pwdata"},  32'(bus.PWDATA_o),  32'd0);
        check({tag, "_psel"},    32'(bus.PSEL_o),    32'd0);
        check({tag, "_penable"}, 32'(bus.PENABLE_o), 32'd0);
    endtask

    // Bus monitor: cycle counts, grant order, and protocol/stability checks
    initial begin
        logic [1:0] prev_gnt;
        logic [9:0] h_addr;
        logic       h_wr;
        logic [7:0] h_wd;
        prev_gnt = 2'b00;
        h_addr = '0; h_wr = 1'b0; h_wd = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_gnt = 2'b00;
            end else begin
                if (bus.gnt_o == 2'b11)
                    check("gnt_both", 32'(bus.gnt_o), 32'd1);
                if (bus.PENABLE_o && !bus.PSEL_o)
                    check("penable_wo_psel", 32'(bus.PSEL_o), 32'd1);
                if (bus.PSEL_o && !bus.PENABLE_o) begin
                    setup_cyc++;
                    h_addr = bus.PADDR_o; h_wr = bus.PWRITE_o; h_wd = bus.PWDATA_o;
                end
                if (bus.PSEL_o && bus.PENABLE_o) begin
                    acc_cyc++;
                    check("hold_paddr",  32'(bus.PADDR_o),  32'(h_addr));
                    check("hold_pwrite", 32'(bus.PWRITE_o), 32'(h_wr));
                    check("hold_pwdata", 32'(bus.PWDATA_o), 32'(h_wd));
                end
                if (bus.gnt_o != 2'b00) gnt_cyc++;
                if (prev_gnt == 2'b00 && bus.gnt_o != 2'b00)
                    order.push_back(bus.gnt_o == 2'b10 ? 1 : 0);
                prev_gnt = bus.gnt_o;
            end
        end
    end

    // One requester transaction: push the expectation, request, wait for done, compare
    task automatic xfer(input int r, input logic w, input logic [9:0] a, input logic [7:0] d,
                        input logic [7:0] erd, input logic eerr);
        exp_t       e;
        exp_t       got;
        logic [1:0] mask;
        int         n;
        mask   = (r == 1) ? 2'b10 : 2'b01;
        e.done = mask; e.rd = erd; e.err = eerr;
        if (r == 0) begin
            q0.push_back(e); wr0 = w; a0 = a; d0 = d; req0 = 1'b1;
        end else begin
            q1.push_back(e); wr1 = w; a1 = a; d1 = d; req1 = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.done_o & mask) == 2'b00 && n < 200);
        check($sformatf("done_seen_r%0d", r), 32'(bus.done_o & mask), 32'(mask));
        if (r == 0) e = q0.pop_front(); else e = q1.pop_front();
        got.done = bus.done_o; got.rd = bus.rdata_o; got.err = bus.err_o;
        check($sformatf("done_r%0d", r),  32'(got.done), 32'(e.done));
        check($sformatf("rdata_r%0d", r), 32'(got.rd),   32'(e.rd));
        check($sformatf("err_r%0d", r),   32'(got.err),  32'(e.err));
        if (r == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic clear_stats();
        setup_cyc = 0; acc_cyc = 0; gnt_cyc = 0;
        order.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        int   wl;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        // 1: r0 zero-wait write
        clear_stats(); wlog.delete(); ws = 0;
        xfer(0, 1'b1, 10'h000, 8'hA5, 8'h00, 1'b0);
        @(negedge clk);
        check("t1_done_pulse", 32'(bus.done_o), 32'd0);
        check("t1_setup_cyc", 32'(setup_cyc), 32'd1);
        check("t1_acc_cyc", 32'(acc_cyc), 32'd1);
        check("t1_gnt_cyc", 32'(gnt_cyc), 32'd3);
        check("t1_wlog_n", 32'(wlog.size()), 32'd1);
        if (wlog.size() > 0) begin
            check("t1_wlog_a", 32'(wlog[0].a), 32'h000);
            check("t1_wlog_d", 32'(wlog[0].d), 32'hA5);
        end

        // 2: r1 read with 3 wait states
        clear_stats(); ws = 3;
        xfer(1, 1'b0, 10'h008, 8'hEE, 8'h16, 1'b0);
        @(negedge clk);
        ws = 0;
        check("t2_acc_cyc", 32'(acc_cyc), 32'd4);
        check("t2_gnt_cyc", 32'(gnt_cyc), 32'd6);
        check("t2_idle_psel", 32'(bus.PSEL_o), 32'd0);

        // 3: both requesters back-to-back, must alternate
        clear_stats(); wlog.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    xfer(0, 1'b1, 10'(32'h020 + i), 8'(32'h30 + i), 8'h00, 1'b0);
                    @(negedge clk);
                end
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    xfer(1, 1'b0, 10'(32'h040 + j), 8'h00, slave_data(10'(32'h040 + j)), 1'b0);
                    @(negedge clk);
                end
            end
        join
        check("t3_order_n", 32'(order.size()), 32'd8);
        for (int k = 0; k < order.size() && k < 8; k++)
            check($sformatf("t3_order%0d", k), 32'(order[k]), 32'(k % 2));
        check("t3_wlog_n", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) begin
            check("t3_wlog3_a", 32'(wlog[3].a), 32'h023);
            check("t3_wlog3_d", 32'(wlog[3].d), 32'h33);
        end

        // 4: slave error, then a clean transfer
        wl = wlog.size();
        err_addr = 10'h014;
        xfer(0, 1'b1, 10'h014, 8'h77, 8'h00, 1'b1);
        @(negedge clk);
        check("t4_err_cleared", 32'(bus.err_o), 32'd0);
        check("t4_no_log", 32'(wlog.size()), 32'(wl));
        err_addr = 10'h3FF;
        xfer(0, 1'b0, 10'h015, 8'h00, slave_data(10'h015), 1'b0);
        @(negedge clk);

        // 5: timeout on a stalled read
        clear_stats(); stall = 1'b1;
        xfer(1, 1'b0, 10'h030, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        stall = 1'b0;
        check("t5_acc_cyc", 32'(acc_cyc), 32'(TIMEOUT));
        check("t5_gnt_cyc", 32'(gnt_cyc), 32'(TIMEOUT + 2));
        check("t5_idle_gnt", 32'(bus.gnt_o), 32'd0);

        // 6: reset in the 2nd ACCESS cycle, then a tie must go to r0
        stall = 1'b1; wr1 = 1'b0; a1 = 10'h050; req1 = 1'b1;
        n = 0;
        while (!(bus.PENABLE_o && acc_cnt == 1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_reached_access2", 32'(bus.PENABLE_o), 32'd1);
        #1 rstn = 1'b0;
        #1 check_all_zero("t6_reset");
        req1 = 1'b0; stall = 1'b0;
        @(negedge clk);
        check("t6_no_done", 32'(bus.done_o), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        clear_stats();
        fork
            xfer(0, 1'b1, 10'h060, 8'h99, 8'h00, 1'b0);
            xfer(1, 1'b0, 10'h061, 8'h00, slave_data(10'h061), 1'b0);
        join
        @(negedge clk);
        check("t6_order_n", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            check("t6_first", 32'(order[0]), 32'd0);
            check("t6_second", 32'(order[1]), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
